// File: rtl/classificador_pkg.sv
// classificador_pkg
//   Shared types and default constants for the button/sensor input
//   conditioning stage (classificador_botao and filtro_debounce).
package classificador_pkg;

   // Press classifier states
   typedef enum logic [1:0] {
      IDLE          = 2'd0,
      CONTANDO      = 2'd1,
      ESPERA_SOLTAR = 2'd2
   } estado_t;

   localparam int DEBOUNCE_CYCLES_DEF   = 50;
   localparam int LONG_PRESS_CYCLES_DEF = 3000;

endpackage

// File: rtl/filtro_debounce.sv
// filtro_debounce
//   Two-flop synchronizer followed by a debounce counter. The stable level
//   flips only after DEBOUNCE_CYCLES+1 consecutive synchronized samples that
//   disagree with it, which puts the flip 2 + DEBOUNCE_CYCLES edges after the
//   first edge that samples a clean raw change.
// Ports:
//   clk     - system clock
//   rst     - asynchronous reset, active-low
//   entrada - raw asynchronous input
//   estavel - debounced level
module filtro_debounce
   import classificador_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic entrada,
   output logic estavel
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

   logic          sinc1, sinc2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sinc1   <= 1'b0;
         sinc2   <= 1'b0;
         cnt     <= '0;
         estavel <= 1'b0;
      end else begin
         sinc1 <= entrada;
         sinc2 <= sinc1;
         // A matching sample has priority: any agreement restarts the count.
         if (sinc2 == estavel) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            estavel <= ~estavel;
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/classificador_botao.sv
// classificador_botao
//   Input conditioning upstream of the lamp mode controller. Debounces the
//   push button and classifies each press:
//     a - one-cycle pulse, long press (held LONG_PRESS_CYCLES debounced cycles)
//     b - one-cycle pulse, short press released before that point
//     d - presence level, synchronized sensor
// Build option:
//   SENSOR_DEBOUNCE_EN - when defined, the sensor also goes through a
//   filtro_debounce instance; otherwise it is only synchronized.
// Ports:
//   clk    - system clock
//   rst    - asynchronous reset, active-low
//   botao  - raw push button, active-high
//   sensor - raw presence sensor, active-high
//   a, b, d as above
module classificador_botao
   import classificador_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic botao,
   input  logic sensor,
   output logic a,
   output logic b,
   output logic d
);

   localparam int HW = $clog2(LONG_PRESS_CYCLES);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_PRESS_CYCLES - 2);

   estado_t       estado, prox;
   logic [HW-1:0] hold, hold_prox;
   logic          a_prox, b_prox;
   logic          bt_est;
   logic          sn_nivel;

   filtro_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_botao (
      .clk     (clk),
      .rst     (rst),
      .entrada (botao),
      .estavel (bt_est)
   );

`ifdef SENSOR_DEBOUNCE_EN
   filtro_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sensor (
      .clk     (clk),
      .rst     (rst),
      .entrada (sensor),
      .estavel (sn_nivel)
   );
`else
   // Level flop sits where the debounce's stable flop would be, so the
   // filtered build is exactly DEBOUNCE_CYCLES edges slower than this one.
   logic sn_s1, sn_s2;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sn_s1    <= 1'b0;
         sn_s2    <= 1'b0;
         sn_nivel <= 1'b0;
      end else begin
         sn_s1    <= sensor;
         sn_s2    <= sn_s1;
         sn_nivel <= sn_s2;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         estado <= IDLE;
         hold   <= '0;
         a      <= 1'b0;
         b      <= 1'b0;
         d      <= 1'b0;
      end else begin
         estado <= prox;
         hold   <= hold_prox;
         a      <= a_prox;
         b      <= b_prox;
         d      <= sn_nivel;
      end
   end

   // The long-press pulse is registered on the same edge that moves the hold
   // counter to LONG_PRESS_CYCLES-1, so a is high while hold sits there.
   always_comb begin
      prox      = estado;
      hold_prox = hold;
      a_prox    = 1'b0;
      b_prox    = 1'b0;
      case (estado)
         IDLE: begin
            if (bt_est) begin
               prox      = CONTANDO;
               hold_prox = '0;
            end
         end
         CONTANDO: begin
            if (!bt_est) begin
               b_prox = 1'b1;
               prox   = IDLE;
            end else begin
               if (hold != HOLD_LAST) hold_prox = hold + 1'b1;
               if (hold == HOLD_PRE) begin
                  a_prox = 1'b1;
                  prox   = ESPERA_SOLTAR;
               end
            end
         end
         ESPERA_SOLTAR: begin
            if (!bt_est) prox = IDLE;
         end
         default: prox = IDLE;
      endcase
   end

endmodule

// File: tb/tb_classificador_botao.sv
module tb_classificador_botao;

   localparam int D = 4;
   localparam int L = 20;
   localparam int HMAX = 4096;

   logic clk = 1'b0, rst = 1'b0, botao = 1'b0, sensor = 1'b0;
   logic a, b, d;

   always #5 clk = ~clk;

   classificador_botao #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
      .clk    (clk),
      .rst    (rst),
      .botao  (botao),
      .sensor (sensor),
      .a      (a),
      .b      (b),
      .d      (d)
   );

   int n_chk = 0, n_err = 0;

   task automatic check(input string nome, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nome, act, exp);
      end
   endtask

   // edge counter: at a negedge, cyc is the index of the next posedge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   // Raw samples are recorded per edge since the last reset. A level flips
   // when the D+1 synchronized samples ending now all disagree with it; the
   // synchronized sample seen at edge e is the raw sample taken at e-2.
   // A press is the run of cycles the debounced level stays high: run reaching
   // L gives a, a run ending below L gives b, each one edge after the fact.
   bit hb[0:HMAX-1];
   bit hs[0:HMAX-1];
   int e;
   bit st1, st2, sst1;
   int run1, run2;
   bit exp_a, exp_b, exp_d;
   bit model_ok = 1'b0;

   function automatic bit raw_at(input bit sel, input int i);
      if (i < 0 || i >= HMAX) return 1'b0;
      return sel ? hs[i] : hb[i];
   endfunction

   function automatic bit flips(input bit sel, input int ee, input bit cur);
      for (int k = 0; k <= D; k++)
         if (raw_at(sel, ee - k - 2) == cur) return 1'b0;
      return 1'b1;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         e = 0; st1 = 0; st2 = 0; sst1 = 0; run1 = 0; run2 = 0;
         exp_a = 0; exp_b = 0; exp_d = 0;
         model_ok = 1'b1;
      end else begin
         bit st0;
         int run0;
         if (e < HMAX) begin
            hb[e] = botao;
            hs[e] = sensor;
         end
         exp_a = st1 && (run1 == L);
         exp_b = !st1 && st2 && (run2 < L);
`ifdef SENSOR_DEBOUNCE_EN
         exp_d = sst1;
         if (flips(1'b1, e, sst1)) sst1 = !sst1;
`else
         exp_d = raw_at(1'b1, e - 3);
`endif
         st0  = flips(1'b0, e, st1) ? !st1 : st1;
         run0 = st0 ? run1 + 1 : 0;
         st2 = st1; run2 = run1;
         st1 = st0; run1 = run0;
         e++;
      end
   end

   // every-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (model_ok) begin
         check("a_cycle", a, exp_a);
         check("b_cycle", b, exp_b);
         check("d_cycle", d, exp_d);
      end
   end

   // pulse / edge monitor for the literal expectations
   int a_cnt = 0, b_cnt = 0, d_rises = 0;
   int last_a = -1, last_b = -1, last_d = -1;
   bit d_prev = 1'b0;
   initial forever begin
      @(negedge clk);
      if (a === 1'b1) begin a_cnt++; last_a = cyc - 1; end
      if (b === 1'b1) begin b_cnt++; last_b = cyc - 1; end
      if (d === 1'b1 && !d_prev) begin d_rises++; last_d = cyc - 1; end
      d_prev = (d === 1'b1);
   end

   task automatic set_b(input logic v, output int ed);
      @(negedge clk);
      botao = v;
      ed = cyc;
   endtask

   task automatic set_s(input logic v, output int ed);
      @(negedge clk);
      sensor = v;
      ed = cyc;
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   int P, R, S, E0, a0, b0, d0;

   initial begin
      // reset state
      wait_n(3);
      check("rst_a", a, 0);
      check("rst_b", b, 0);
      check("rst_d", d, 0);
      @(negedge clk);
      rst = 1'b1;
      wait_n(5);

      // 1: clean short press, 12 cycles
      a0 = a_cnt; b0 = b_cnt;
      set_b(1'b1, P); wait_n(11); set_b(1'b0, R); wait_n(30);
      check("short_b_count", b_cnt - b0, 1);
      check("short_b_latency", last_b - R, 7);
      check("short_a_count", a_cnt - a0, 0);

      // 2: long press, 40 cycles
      a0 = a_cnt; b0 = b_cnt;
      set_b(1'b1, P); wait_n(39); set_b(1'b0, R); wait_n(30);
      check("long_a_count", a_cnt - a0, 1);
      check("long_a_latency", last_a - P, 26);
      check("long_b_count", b_cnt - b0, 0);

      // 3: bounce 1,1,0,0,... for 10 cycles
      a0 = a_cnt; b0 = b_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         botao = ((i % 4) < 2);
      end
      @(negedge clk); botao = 1'b0;
      wait_n(25);
      check("bounce_a_count", a_cnt - a0, 0);
      check("bounce_b_count", b_cnt - b0, 0);

      // 6a: 19 debounced cycles -> short
      a0 = a_cnt; b0 = b_cnt;
      set_b(1'b1, P); wait_n(18); set_b(1'b0, R); wait_n(30);
      check("b19_b_count", b_cnt - b0, 1);
      check("b19_b_latency", last_b - P, 26);
      check("b19_a_count", a_cnt - a0, 0);

      // 6b: 20 debounced cycles -> long
      a0 = a_cnt; b0 = b_cnt;
      set_b(1'b1, P); wait_n(19); set_b(1'b0, R); wait_n(30);
      check("b20_a_count", a_cnt - a0, 1);
      check("b20_a_latency", last_a - P, 26);
      check("b20_b_count", b_cnt - b0, 0);

      // 5: sensor
      d0 = d_rises;
`ifdef SENSOR_DEBOUNCE_EN
      set_s(1'b1, S); wait_n(2); set_s(1'b0, R); wait_n(15);
      check("glitch_d_rises", d_rises - d0, 0);
      set_s(1'b1, S); wait_n(14);
      check("sensor_d_rises", d_rises - d0, 1);
      check("sensor_d_latency", last_d - S, 7);
`else
      set_s(1'b1, S); wait_n(10);
      check("sensor_d_rises", d_rises - d0, 1);
      check("sensor_d_latency", last_d - S, 3);
`endif

      // 4: reset mid-press with button and sensor held
      set_b(1'b1, P); wait_n(10);
      check("mid_d_pre", d, 1);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("mid_rst_a", a, 0);
      check("mid_rst_b", b, 0);
      check("mid_rst_d", d, 0);
      wait_n(2);
      rst = 1'b1;
      E0 = cyc; a0 = a_cnt; b0 = b_cnt;
      wait_n(35);
      check("mid_a_count", a_cnt - a0, 1);
      check("mid_a_latency", last_a - E0, 26);
      set_b(1'b0, R); wait_n(30);
      check("mid_b_count", b_cnt - b0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
